// File: rtl/rgbw_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : rgbw_spi_master
// Purpose  : Sends one 7-byte RGBW frame (mode, lint, color_idx, red, green,
//            blue, white) per start request over a mode-0 SPI link, MSB first.
//            Bytes are separated by a programmable gap with CS held low.
// Ports    : clk_i         system clock, rising-edge active
//            rst_ni        asynchronous active-low reset
//            start_i       one-cycle frame request (accepted only when idle)
//            abort_i       terminates the frame in progress on the next edge
//            mode_i..white_i  payload bytes, captured in the start cycle
//            busy_o        high while a frame is in progress
//            done_o        one-cycle pulse on normal frame completion
//            sck_o/mosi_o/cs_o  SPI clock, data and active-low chip select
// Revision : 1.0 - initial release
// ============================================================================
module rgbw_spi_master #(
  parameter int unsigned CLK_DIV    = 4,  // SCK half-period in clk cycles, 2..255
  parameter int unsigned GAP_CYCLES = 8   // inter-byte gap in clk cycles, 1..255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] mode_i,
  input  logic [7:0] lint_i,
  input  logic [7:0] color_idx_i,
  input  logic [7:0] red_i,
  input  logic [7:0] green_i,
  input  logic [7:0] blue_i,
  input  logic [7:0] white_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       sck_o,
  output logic       mosi_o,
  output logic       cs_o
);

  localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] C_GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_GAP   = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [55:0] shreg_q, shreg_d;
  logic [7:0]  div_q,   div_d;    // cycles within the current phase
  logic [2:0]  bit_q,   bit_d;    // bits already started in this byte, 7 = bit 0
  logic [2:0]  byte_q,  byte_d;   // completed bytes, reaches 7 at HOLD entry
  logic        sck_q,   sck_d;
  logic        cs_q,    cs_d;
  logic        done_q,  done_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sck_d   = sck_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        sck_d = 1'b0;
        if (start_i) begin
          shreg_d = {mode_i, lint_i, color_idx_i, red_i, green_i, blue_i, white_i};
          state_d = S_SETUP;
          div_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end

      S_SETUP: begin
        if (div_q == C_DIV_LAST) begin
          div_d   = '0;
          sck_d   = 1'b1;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_SHIFT: begin
        if (div_q != C_DIV_LAST) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (sck_q) begin
            // Falling edge: advance MOSI, except after bit 0 where the next
            // byte's MSB is presented at gap/hold entry instead.
            sck_d = 1'b0;
            if (bit_q != 3'd7) begin
              shreg_d = {shreg_q[54:0], 1'b0};
            end
          end else if (bit_q != 3'd7) begin
            bit_d = bit_q + 3'd1;
            sck_d = 1'b1;
          end else begin
            // End of the low half of bit 0. After the 56th shift the register
            // is empty, so MOSI returns to 0 for HOLD and IDLE.
            bit_d   = '0;
            byte_d  = byte_q + 3'd1;
            shreg_d = {shreg_q[54:0], 1'b0};
            state_d = (byte_q == 3'd6) ? S_HOLD : S_GAP;
          end
        end
      end

      S_GAP: begin
        if (div_q == C_GAP_LAST) begin
          div_d   = '0;
          sck_d   = 1'b1;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_HOLD: begin
        if (div_q == C_DIV_LAST) begin
          div_d   = '0;
          byte_d  = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        sck_d   = 1'b0;
      end
    endcase

    // Abort overrides everything once a frame is running; in IDLE it is
    // ignored so a simultaneous start still launches a frame.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      shreg_d = '0;
      div_d   = '0;
      bit_d   = '0;
      byte_d  = '0;
      sck_d   = 1'b0;
      done_d  = 1'b0;
    end

    cs_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
    end
  end

  // CS is low in exactly the non-idle states, so busy is its complement.
  assign busy_o = ~cs_q;
  assign done_o = done_q;
  assign sck_o  = sck_q;
  assign cs_o   = cs_q;
  assign mosi_o = shreg_q[55];

endmodule
`default_nettype wire

// File: tb/tb_rgbw_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgbw_spi_master
// Purpose  : Self-checking bench for rgbw_spi_master. Two instances: default
//            parameters (A) and CLK_DIV=2 / GAP_CYCLES=1 (B). Expected bytes
//            are queued when a frame is started and compared as an SPI
//            receiver model decodes them from the wire.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgbw_spi_master;

  `define CHK(TAG, OBS, EXP) begin n_chk++; assert ((OBS) === (EXP)) else begin n_fail++; $error("FAIL %s: observed %0h expected %0h", TAG, (OBS), (EXP)); end end

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, abort_a, start_b, abort_b;
  logic [55:0] pay_a, pay_b;
  logic busy_a, done_a, sck_a, mosi_a, cs_a;
  logic busy_b, done_b, sck_b, mosi_b, cs_b;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  int run[2], low_cnt[2], frise[2], bitc[2], flen[2], frises[2];
  int hi_run[2], hi_len[2], done_cnt[2], done_cyc[2], rxb[2], start_cyc[2];
  logic psck[2], pcs[2];
  logic [7:0] shr[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rgbw_spi_master u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .abort_i(abort_a),
    .mode_i(pay_a[55:48]), .lint_i(pay_a[47:40]), .color_idx_i(pay_a[39:32]),
    .red_i(pay_a[31:24]), .green_i(pay_a[23:16]), .blue_i(pay_a[15:8]),
    .white_i(pay_a[7:0]),
    .busy_o(busy_a), .done_o(done_a), .sck_o(sck_a), .mosi_o(mosi_a), .cs_o(cs_a)
  );

  rgbw_spi_master #(.CLK_DIV(2), .GAP_CYCLES(1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .abort_i(abort_b),
    .mode_i(pay_b[55:48]), .lint_i(pay_b[47:40]), .color_idx_i(pay_b[39:32]),
    .red_i(pay_b[31:24]), .green_i(pay_b[23:16]), .blue_i(pay_b[15:8]),
    .white_i(pay_b[7:0]),
    .busy_o(busy_b), .done_o(done_b), .sck_o(sck_b), .mosi_o(mosi_b), .cs_o(cs_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Receiver model: samples on the falling clk edge, checks SCK run lengths,
  // decodes MOSI at SCK rising edges and compares against the queue.
  task automatic mon(input int d, input logic sck, input logic cs,
                     input logic mosi, input logic done);
    int div, gap, qn, exp_run;
    logic [7:0] nb, exp_b;
    div = (d == 0) ? 4 : 2;
    gap = (d == 0) ? 8 : 1;
    if (done) begin
      done_cnt[d]++;
      done_cyc[d] = cyc;
      `CHK("done_on_cs_rise", (cs && !pcs[d]), 1'b1)
    end
    if (!cs && pcs[d]) begin
      hi_len[d] = hi_run[d];
      low_cnt[d] = 1;
      run[d] = 1;
      frise[d] = 0;
      bitc[d] = 0;
    end else if (!cs) begin
      low_cnt[d]++;
      if (sck != psck[d]) begin
        if (sck) begin
          exp_run = (bitc[d] == 0 && frise[d] > 0) ? div + gap : div;
          `CHK("sck_low_run", run[d], exp_run)
          frise[d]++;
          nb = {shr[d][6:0], mosi};
          shr[d] = nb;
          bitc[d]++;
          if (bitc[d] == 8) begin
            bitc[d] = 0;
            qn = (d == 0) ? qa.size() : qb.size();
            `CHK("rx_byte_expected", (qn > 0), 1'b1)
            if (qn > 0) begin
              if (d == 0) exp_b = qa.pop_front();
              else        exp_b = qb.pop_front();
              rxb[d]++;
              `CHK("rx_byte", nb, exp_b)
            end
          end
        end else begin
          `CHK("sck_high_run", run[d], div)
        end
        run[d] = 1;
      end else begin
        run[d]++;
      end
    end else if (!pcs[d]) begin
      flen[d] = low_cnt[d];
      frises[d] = frise[d];
      hi_run[d] = 1;
      bitc[d] = 0;
    end else begin
      hi_run[d]++;
    end
    psck[d] = sck;
    pcs[d] = cs;
  endtask

  always @(negedge clk) begin
    mon(0, sck_a, cs_a, mosi_a, done_a);
    mon(1, sck_b, cs_b, mosi_b, done_b);
  end

  // Called at (or just after) a falling edge: start is sampled on the next
  // rising edge, then payload is scrambled to prove it was latched.
  task automatic send(input int d, input logic [55:0] f, input logic ab);
    if (d == 0) begin
      pay_a = f; start_a = 1'b1; abort_a = ab;
      for (int i = 0; i < 7; i++) qa.push_back(f[55-8*i -: 8]);
    end else begin
      pay_b = f; start_b = 1'b1; abort_b = ab;
      for (int i = 0; i < 7; i++) qb.push_back(f[55-8*i -: 8]);
    end
    start_cyc[d] = cyc;
    @(negedge clk);
    if (d == 0) begin
      start_a = 1'b0; abort_a = 1'b0; pay_a = 56'({$urandom(), $urandom()});
    end else begin
      start_b = 1'b0; abort_b = 1'b0; pay_b = 56'({$urandom(), $urandom()});
    end
  endtask

  task automatic wait_done(input int d, input int lim);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      seen = (d == 0) ? done_a : done_b;
    end
    #1;
    chk("done_within_bound", seen, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      run[i] = 0; low_cnt[i] = 0; frise[i] = 0; bitc[i] = 0; flen[i] = 0;
      frises[i] = 0; hi_run[i] = 0; hi_len[i] = 0; done_cnt[i] = 0;
      done_cyc[i] = 0; rxb[i] = 0; start_cyc[i] = 0;
      psck[i] = 1'b0; pcs[i] = 1'b1; shr[i] = 8'h00;
    end
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; pay_a = '0;
    start_b = 1'b0; abort_b = 1'b0; pay_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_cs", cs_a, 1'b1);
    chk("reset_sck", sck_a, 1'b0);
    chk("reset_mosi", mosi_a, 1'b0);
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_done", done_a, 1'b0);

    // First frame: start offered together with reset release.
    rst_n = 1'b1;
    send(0, 56'h01_80_05_FF_00_AA_3C, 1'b0);
    `CHK("busy_after_start", busy_a, 1'b1)
    `CHK("cs_after_start", cs_a, 1'b0)
    wait_done(0, 700);
    `CHK("done_cycle", done_cyc[0] - start_cyc[0], 505)
    `CHK("cs_low_len", flen[0], 504)
    `CHK("sck_rises", frises[0], 56)
    `CHK("rx_count_f1", rxb[0], 7)
    `CHK("busy_in_done_cycle", busy_a, 1'b0)
    @(negedge clk);
    `CHK("done_one_cycle", done_a, 1'b0)

    // Start during a frame is ignored.
    send(0, 56'hDE_AD_BE_EF_12_34_56, 1'b0);
    repeat (99) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, 700);
    repeat (40) @(negedge clk);
    `CHK("ignored_start_busy", busy_a, 1'b0)
    `CHK("ignored_start_dones", done_cnt[0], 2)
    `CHK("ignored_start_rx", rxb[0], 14)

    // Abort in IDLE does nothing.
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    `CHK("idle_abort_cs", cs_a, 1'b1)
    `CHK("idle_abort_busy", busy_a, 1'b0)

    // Abort during byte 3 bit 4 (cycles 245..252 after the start cycle).
    send(0, 56'hA5_5A_F0_0F_C3_3C_81, 1'b0);
    repeat (247) @(negedge clk);
    `CHK("pre_abort_busy", busy_a, 1'b1)
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    `CHK("abort_cs", cs_a, 1'b1)
    `CHK("abort_sck", sck_a, 1'b0)
    `CHK("abort_mosi", mosi_a, 1'b0)
    `CHK("abort_busy", busy_a, 1'b0)
    `CHK("abort_done", done_a, 1'b0)
    `CHK("abort_rx_partial", rxb[0], 17)
    qa.delete();
    repeat (10) @(negedge clk);
    `CHK("abort_no_done", done_cnt[0], 2)

    // Start and abort together in IDLE: start wins, full frame follows.
    send(0, 56'h7E_81_00_FF_55_AA_01, 1'b1);
    wait_done(0, 700);
    `CHK("start_wins_done_cycle", done_cyc[0] - start_cyc[0], 505)
    `CHK("start_wins_rx", rxb[0], 24)
    `CHK("start_wins_dones", done_cnt[0], 3)

    // Back-to-back: start in the done cycle.
    send(0, 56'h11_22_33_44_55_66_77, 1'b0);
    wait_done(0, 700);
    `CHK("b2b_cs_high", hi_len[0], 1)
    `CHK("b2b_cs_low_len", flen[0], 504)
    `CHK("b2b_rx", rxb[0], 31)
    `CHK("b2b_dones", done_cnt[0], 4)

    // Reset mid-SHIFT: outputs return to reset values without a clock edge.
    send(0, 56'hC0_FF_EE_00_11_22_33, 1'b0);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    `CHK("midrst_cs", cs_a, 1'b1)
    `CHK("midrst_sck", sck_a, 1'b0)
    `CHK("midrst_mosi", mosi_a, 1'b0)
    `CHK("midrst_busy", busy_a, 1'b0)
    `CHK("midrst_done", done_a, 1'b0)
    repeat (3) @(negedge clk);
    `CHK("midrst_no_done", done_cnt[0], 4)
    `CHK("midrst_no_rx", rxb[0], 31)
    qa.delete();
    rst_n = 1'b1;
    @(negedge clk);

    // Minimum parameters: 1 + 2 + 224 + 6 + 2 = 235 cycles to cs high.
    send(1, 56'h01_80_05_FF_00_AA_3C, 1'b0);
    wait_done(1, 400);
    `CHK("min_done_cycle", done_cyc[1] - start_cyc[1], 235)
    `CHK("min_cs_low_len", flen[1], 234)
    `CHK("min_sck_rises", frises[1], 56)
    `CHK("min_rx", rxb[1], 7)

    repeat (5) @(negedge clk);
    `CHK("queue_a_drained", qa.size(), 0)
    `CHK("queue_b_drained", qb.size(), 0)
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  `undef CHK

endmodule
`default_nettype wire
